// File: rtl/mod_counter.sv
// mod_counter: modulo up/down counter with synchronous clear, clamped
// parallel load, enable and a selectable boundary mode (wrap, saturate,
// one-shot). Emits a one-cycle event pulse on boundary activity and a
// sticky completion flag in one-shot mode.
module mod_counter #(
   parameter int               WIDTH = 8,
   parameter logic [WIDTH-1:0] MAX   = {WIDTH{1'b1}},
   parameter int               MODE  = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   input  logic             up,
   output logic [WIDTH-1:0] count,
   output logic             evt,
   output logic             done,
   output logic             at_max,
   output logic             at_zero
);

   localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] MAX_M1  = MAX - ONE;
   localparam bit               WRAP    = (MODE == 0);
   localparam bit               ONESHOT = (MODE == 2);

   logic [WIDTH-1:0] count_p0;
   logic             evt_p0;
   logic             done_p0;

   logic [WIDTH-1:0] count_nxt;
   logic             evt_nxt;
   logic             done_nxt;

   // Loaded values above the terminal value are pulled back to MAX so the
   // count never leaves the 0..MAX range.
   function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
      return (v > MAX) ? MAX : v;
   endfunction

   // Next-state: clr beats load beats an enabled step; otherwise hold.
   always_comb begin
      count_nxt = count_p0;
      evt_nxt   = 1'b0;
      done_nxt  = done_p0;
      if (clr) begin
         count_nxt = '0;
         done_nxt  = 1'b0;
      end else if (load) begin
         count_nxt = clamp_load(load_val);
         done_nxt  = 1'b0;
      end else if (en && !(ONESHOT && done_p0)) begin
         if (up) begin
            if (count_p0 == MAX) begin
               // Step past the top: wrap to 0, or hold for saturate/one-shot.
               evt_nxt = 1'b1;
               if (WRAP)    count_nxt = '0;
               if (ONESHOT) done_nxt  = 1'b1;
            end else begin
               count_nxt = count_p0 + ONE;
               if (ONESHOT && (count_p0 == MAX_M1)) begin
                  done_nxt = 1'b1;
                  evt_nxt  = 1'b1;
               end
            end
         end else begin
            if (count_p0 == '0) begin
               // Step past the bottom: wrap to MAX, or hold.
               evt_nxt = 1'b1;
               if (WRAP)    count_nxt = MAX;
               if (ONESHOT) done_nxt  = 1'b1;
            end else begin
               count_nxt = count_p0 - ONE;
               if (ONESHOT && (count_p0 == ONE)) begin
                  done_nxt = 1'b1;
                  evt_nxt  = 1'b1;
               end
            end
         end
      end
   end

   // Stage p0: registered count, event pulse and completion flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_p0 <= '0;
         evt_p0   <= 1'b0;
         done_p0  <= 1'b0;
      end else begin
         count_p0 <= count_nxt;
         evt_p0   <= evt_nxt;
         done_p0  <= done_nxt;
      end
   end

   assign count   = count_p0;
   assign evt     = evt_p0;
   assign done    = done_p0;
   assign at_max  = (count_p0 == MAX);
   assign at_zero = (count_p0 == '0);

endmodule

// File: doc/mod_counter.md
# mod_counter

Parametrised modulo up/down counter with synchronous clear, parallel load, enable, and three boundary modes: wrap, saturate and one-shot. It replaces the fixed 4-bit free-running up-counter wherever a design needs a configurable width, a non-power-of-two modulus, a count direction, or a terminal-count event. Typical uses are tick prescalers, timeout timers and bounded index generators.

## Interface
- WIDTH, 8: counter width in bits; legal values are 2..32.
- MAX, 2**WIDTH-1: terminal value; the count range is 0..MAX. MAX must satisfy 1 <= MAX <= 2**WIDTH-1.
- MODE, 0: boundary behaviour; 0 = wrap, 1 = saturate, 2 = one-shot.

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous clear to 0.
- load  in  1  synchronous parallel load.
- load_val  in  WIDTH  value captured on load.
- en  in  1  count enable; one step per enabled clk edge.
- up  in  1  direction; 1 = increment, 0 = decrement.
- count  out  WIDTH  registered count value.
- evt  out  1  registered one-cycle boundary-event pulse.
- done  out  1  registered one-shot completion flag; sticky.
- at_max  out  1  combinational, (count == MAX).
- at_zero  out  1  combinational, (count == 0).

## Operation
- Reset (asynchronous, any time): count=0, evt=0, done=0. The block therefore resets with at_zero=1 and at_max=0.
- Per-edge priority is clr > load > en-step > hold.
  - Evaluation is deferred (reset deasserted) and happens only at a clk edge.
- clr: count=0, done=0, evt=0.
- load: count=load_val, or MAX if load_val > MAX (clamp). Load also sets done=0 and evt=0.
- Hold: when en=0 (and no clr/load), count and done keep their values and evt=0.
- Step (en=1), normal case: up=1 and count<MAX gives count+1; up=0 and count>0 gives count-1. evt=0.
- Boundary step: up=1 at count==MAX, or up=0 at count==0.
  - MODE 0 (wrap): up gives MAX to 0; down gives 0 to MAX. evt=1.
  - MODE 1 (saturate): count holds; evt=1 on every attempted step past the boundary.
- MODE 2 (one-shot):
  - A step that lands on the terminal value (MAX when up=1, 0 when up=0) sets done=1 and evt=1 on that same edge.
  - While done=1, en is ignored: count holds and evt=0.
  - Only clr, load or reset restart the counter.
  - A boundary step taken with done=0 (for example, after a load of MAX with up=1) sets done=1 and evt=1, and count holds.
- Arithmetic uses WIDTH bits only, with no extra bits exposed. The wrap target is MAX, not 2**WIDTH-1, so non-power-of-two moduli wrap correctly.
- Direction may change on any cycle. Each step uses the value of up sampled at that edge.
- In MODE 0 and MODE 1, done is constant 0.

## Timing
- Latency is 1 cycle: inputs sampled at edge N take effect in count, evt and done after edge N.
- evt is high for exactly the one cycle following the qualifying edge. Back-to-back qualifying edges give a continuous high (for example, saturate with en held high).
- at_max and at_zero follow count combinationally within the same cycle. There are no other combinational input-to-output paths.
- Reset assertion mid-operation clears all outputs immediately, without waiting for clk. The first step after deassertion happens at the first rising edge where reset=0.
- clr and load asserted together: clr wins, and load_val is ignored.

## Test plan
- MODE=0, WIDTH=4, MAX=9:
  - Stimulus: reset, then en=1, up=1 for 12 edges.
  - Response: count 1..9, 0, 1, 2; evt high only in the cycle count==0; at_max high while count==9.
- MODE=0, MAX=9, down-count from 0:
  - Stimulus: en=1, up=0 for 2 edges.
  - Response: count 9 then 8; evt on the 9 cycle. Then a direction flip (up=1) gives 9, then 0 with evt.
- MODE=1, WIDTH=8, MAX=200:
  - Stimulus: load 250, then 3 up steps.
  - Response: count=200 after the load (clamp), stays at 200, evt=1 for 3 consecutive cycles.
  - Stimulus: then 1 down step.
  - Response: count=199, evt=0.
- MODE=2, MAX=5:
  - Stimulus: reset, then en=1, up=1.
  - Response: count reaches 5 after edge 5; done=1 and evt=1 in that cycle; further enabled edges hold count=5 with evt=0 and done=1.
  - Stimulus: clr.
  - Response: count=0, done=0.
- Async reset and priority:
  - Stimulus: assert reset between clk edges while count=7.
  - Response: count=0 before the next edge.
  - Stimulus: clr=1, load=1, load_val=3 on one edge.
  - Response: count=0.
  - Stimulus: load=1, en=1, load_val=3.
  - Response: count=3, with no step applied.
